// File: rtl/rsa_modexp_ct.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_modexp_ct
//  Purpose  : c = m^e mod n by left-to-right square-and-multiply with a
//             bit-serial interleaved modular multiplier and constant-time mode.
//  Revision : 1.0 - initial release
// ============================================================================
module rsa_modexp_ct #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 const_time,
    input  logic [WIDTH-1:0]     m,
    input  logic [EXP_WIDTH-1:0] e,
    input  logic [WIDTH-1:0]     n,
    output logic [WIDTH-1:0]     c,
    output logic                 busy,
    output logic                 finish,
    output logic                 err
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_idx_w = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(EXP_WIDTH - 1);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_load = 3'd1;
    localparam logic [2:0] c_st_sqr  = 3'd2;
    localparam logic [2:0] c_st_mul  = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    logic [2:0]           r_state;
    logic [WIDTH-1:0]     r_m;
    logic [EXP_WIDTH-1:0] r_e;
    logic [WIDTH-1:0]     r_n;
    logic                 r_ct;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_r;
    logic [c_cnt_w-1:0]   r_bit;
    logic [c_idx_w-1:0]   r_idx;
    logic [WIDTH-1:0]     r_c;
    logic                 r_err;

    logic [WIDTH-1:0]     w_mul_b;
    logic                 w_b_bit;
    logic [WIDTH:0]       w_dbl;
    logic [WIDTH:0]       w_dbl_red;
    logic [WIDTH:0]       w_add;
    logic [WIDTH-1:0]     w_r_next;
    logic                 w_e_bit;

    // One interleaved step: r = ((2r mod n) + b[i]*acc) mod n.
    // Real and dummy multiplies use this identical path.
    always_comb begin
        w_mul_b   = (r_state == c_st_sqr) ? r_acc : r_m;
        w_b_bit   = w_mul_b[r_bit];
        w_dbl     = {r_r, 1'b0};
        w_dbl_red = (w_dbl >= {1'b0, r_n}) ? (w_dbl - {1'b0, r_n}) : w_dbl;
        w_add     = w_b_bit ? (w_dbl_red + {1'b0, r_acc}) : w_dbl_red;
        w_r_next  = (w_add >= {1'b0, r_n}) ? WIDTH'(w_add - {1'b0, r_n})
                                           : w_add[WIDTH-1:0];
        w_e_bit   = r_e[r_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_m     <= '0;
            r_e     <= '0;
            r_n     <= '0;
            r_ct    <= 1'b0;
            r_acc   <= '0;
            r_r     <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_c     <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_m     <= m;
                        r_e     <= e;
                        r_n     <= n;
                        r_ct    <= const_time;
                        r_err   <= 1'b0;
                        r_state <= c_st_load;
                    end
                end
                c_st_load: begin
                    r_acc <= WIDTH'(1);
                    r_r   <= '0;
                    r_bit <= c_bit_last;
                    r_idx <= c_idx_last;
                    if ((r_n < WIDTH'(2)) || (r_m >= r_n)) begin
                        r_err   <= 1'b1;
                        r_c     <= '0;
                        r_state <= c_st_done;
                    end else begin
                        r_state <= c_st_sqr;
                    end
                end
                c_st_sqr, c_st_mul: begin
                    r_r   <= w_r_next;
                    r_bit <= r_bit - 1'b1;
                    if (r_bit == '0) begin
                        r_r   <= '0;
                        r_bit <= c_bit_last;
                        if (r_state == c_st_sqr) begin
                            r_acc <= w_r_next;
                            if (w_e_bit || r_ct) begin
                                r_state <= c_st_mul;
                            end else if (r_idx == '0) begin
                                r_c     <= w_r_next;
                                r_state <= c_st_done;
                            end else begin
                                r_idx <= r_idx - 1'b1;
                            end
                        end else begin
                            // Dummy multiply: product is dropped, only the write enable differs.
                            if (w_e_bit) begin
                                r_acc <= w_r_next;
                            end
                            if (r_idx == '0) begin
                                r_c     <= w_e_bit ? w_r_next : r_acc;
                                r_state <= c_st_done;
                            end else begin
                                r_idx   <= r_idx - 1'b1;
                                r_state <= c_st_sqr;
                            end
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign c      = r_c;
    assign busy   = (r_state != c_st_idle);
    assign finish = (r_state == c_st_done);
    assign err    = r_err;

endmodule
`default_nettype wire
